mux_scan_ctrl: RTL and testbench



---
 rtl/mux_scan_ctrl.sv | 109 ++++++++++
 tb/tb_mux_scan_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_ctrl.sv
// rtl/mux_scan_ctrl.sv - select generator and sampler for a downstream 4:1 mux
// Steps sel through channels 0..3, samples mux_out at the end of each dwell, publishes 4-bit frames.
module mux_scan_ctrl #(
  parameter int DWELL = 4,
  parameter int CNT_W = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       cont,
  input  logic       mux_out,
  output logic [1:0] sel,
  output logic [3:0] sample_o,
  output logic       frame_valid,
  output logic       busy,
  output logic [7:0] frame_cnt
);

  typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

  localparam logic [CNT_W-1:0] DWELL_M1 = CNT_W'(DWELL - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       sel_q, sel_d;
  logic [2:0]       shadow_q, shadow_d;
  logic [3:0]       sample_q, sample_d;
  logic             fv_q, fv_d;
  logic [7:0]       fcnt_q, fcnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sel_q    <= 2'b00;
      shadow_q <= 3'b000;
      sample_q <= 4'b0000;
      fv_q     <= 1'b0;
      fcnt_q   <= 8'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      shadow_q <= shadow_d;
      sample_q <= sample_d;
      fv_q     <= fv_d;
      fcnt_q   <= fcnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sel_d    = sel_q;
    shadow_d = shadow_q;
    sample_d = sample_q;
    fv_d     = 1'b0;
    fcnt_d   = fcnt_q;
    case (state_q)
      IDLE: begin
        sel_d = 2'b00;
        cnt_d = '0;
        if (start && !abort) begin
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (abort) begin
          state_d = IDLE;
          sel_d   = 2'b00;
          cnt_d   = '0;
        end else if (cnt_q != DWELL_M1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          cnt_d = '0;
          case (sel_q)
            2'd0: shadow_d[0] = mux_out;
            2'd1: shadow_d[1] = mux_out;
            2'd2: shadow_d[2] = mux_out;
            default: ;
          endcase
          if (sel_q != 2'd3) begin
            sel_d = sel_q + 2'd1;
          end else begin
            // Channel 3 goes straight from mux_out so the frame lands in one write.
            sample_d = {mux_out, shadow_q};
            fv_d     = 1'b1;
            fcnt_d   = fcnt_q + 8'd1;
            sel_d    = 2'b00;
            if (!cont) begin
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sel         = sel_q;
    sample_o    = sample_q;
    frame_valid = fv_q;
    busy        = (state_q == SCAN);
    frame_cnt   = fcnt_q;
  end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb/tb_mux_scan_ctrl.sv - directed self-checking bench for mux_scan_ctrl
module tb_mux_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, start, abort, cont;
  logic [3:0] in_vec;
  logic       mux_out;
  logic [1:0] sel;
  logic [3:0] sample_o;
  logic       frame_valid, busy;
  logic [7:0] frame_cnt;

  logic       start1, abort1, cont1;
  logic [3:0] in1_vec;
  logic       mux1_out;
  logic [1:0] sel1;
  logic [3:0] sample1_o;
  logic       frame_valid1, busy1;
  logic [7:0] frame_cnt1;

  int         n_checks = 0;
  int         n_fail = 0;
  logic [7:0] exp_cnt;

  always #5 clk = ~clk;

  assign mux_out  = in_vec[sel];
  assign mux1_out = in1_vec[sel1];

  mux_scan_ctrl #(.DWELL(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .cont(cont),
    .mux_out(mux_out), .sel(sel), .sample_o(sample_o),
    .frame_valid(frame_valid), .busy(busy), .frame_cnt(frame_cnt)
  );

  mux_scan_ctrl #(.DWELL(1), .CNT_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .cont(cont1),
    .mux_out(mux1_out), .sel(sel1), .sample_o(sample1_o),
    .frame_valid(frame_valid1), .busy(busy1), .frame_cnt(frame_cnt1)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) tick();
    n_checks++; if ({sel, sample_o, frame_valid, busy, frame_cnt} !== 16'h0) begin n_fail++; $display("FAIL reset_held: got %h expected 0000", {sel, sample_o, frame_valid, busy, frame_cnt}); end
    rst_n = 1'b1;
    tick();
    n_checks++; if ({sel, sample_o, frame_valid, busy, frame_cnt} !== 16'h0) begin n_fail++; $display("FAIL reset_release: got %h expected 0000", {sel, sample_o, frame_valid, busy, frame_cnt}); end
    n_checks++; if ({sel1, busy1, frame_cnt1} !== 11'h0) begin n_fail++; $display("FAIL reset_dwell1: got %h expected 000", {sel1, busy1, frame_cnt1}); end
    exp_cnt = 8'd0;
  endtask

  task automatic test_single;
    logic [1:0] es;
    in_vec = 4'b1101;
    cont = 1'b0;
    pulse_start();
    for (int n = 0; n < 16; n++) begin
      es = 2'(n / 4);
      n_checks++; if (sel !== es) begin n_fail++; $display("FAIL single_sel n=%0d: got %0d expected %0d", n, sel, es); end
      n_checks++; if ({busy, frame_valid} !== 2'b10) begin n_fail++; $display("FAIL single_busy n=%0d: got %b expected 10", n, {busy, frame_valid}); end
      tick();
    end
    exp_cnt = exp_cnt + 8'd1;
    n_checks++; if (sample_o !== 4'b1101) begin n_fail++; $display("FAIL single_sample: got %b expected 1101", sample_o); end
    n_checks++; if (frame_valid !== 1'b1) begin n_fail++; $display("FAIL single_fv: got %b expected 1", frame_valid); end
    n_checks++; if (frame_cnt !== exp_cnt) begin n_fail++; $display("FAIL single_cnt: got %0d expected %0d", frame_cnt, exp_cnt); end
    n_checks++; if ({busy, sel} !== 3'b000) begin n_fail++; $display("FAIL single_idle: got %b expected 000", {busy, sel}); end
    tick();
    n_checks++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL single_fv_pulse: got %b expected 0", frame_valid); end
  endtask

  task automatic test_async_reset;
    in_vec = 4'b1111;
    cont = 1'b1;
    pulse_start();
    repeat (6) tick();
    #3;
    rst_n = 1'b0;
    #1;
    n_checks++; if ({sel, sample_o, frame_valid, busy, frame_cnt} !== 16'h0) begin n_fail++; $display("FAIL async_reset: got %h expected 0000", {sel, sample_o, frame_valid, busy, frame_cnt}); end
    cont = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    exp_cnt = 8'd0;
  endtask

  task automatic test_continuous;
    in_vec = 4'b0110;
    cont = 1'b1;
    pulse_start();
    for (int n = 0; n < 16; n++) begin
      n_checks++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL cont_fv_quiet1 n=%0d: got %b expected 0", n, frame_valid); end
      tick();
    end
    exp_cnt = exp_cnt + 8'd1;
    n_checks++; if ({frame_valid, sample_o} !== 5'b10110) begin n_fail++; $display("FAIL cont_frame1: got %b expected 10110", {frame_valid, sample_o}); end
    n_checks++; if (frame_cnt !== exp_cnt) begin n_fail++; $display("FAIL cont_cnt1: got %0d expected %0d", frame_cnt, exp_cnt); end
    in_vec = 4'b1111;
    for (int n = 0; n < 15; n++) begin
      tick();
      n_checks++; if ({busy, frame_valid} !== 2'b10) begin n_fail++; $display("FAIL cont_gap n=%0d: got %b expected 10", n, {busy, frame_valid}); end
    end
    tick();
    exp_cnt = exp_cnt + 8'd1;
    n_checks++; if ({frame_valid, sample_o} !== 5'b11111) begin n_fail++; $display("FAIL cont_frame2: got %b expected 11111", {frame_valid, sample_o}); end
    n_checks++; if (frame_cnt !== exp_cnt) begin n_fail++; $display("FAIL cont_cnt2: got %0d expected %0d", frame_cnt, exp_cnt); end
    in_vec = 4'b0011;
    repeat (5) tick();
    cont = 1'b0;
    repeat (11) tick();
    exp_cnt = exp_cnt + 8'd1;
    n_checks++; if ({frame_valid, busy, sample_o} !== 6'b100011) begin n_fail++; $display("FAIL cont_frame3_stop: got %b expected 100011", {frame_valid, busy, sample_o}); end
    n_checks++; if (frame_cnt !== exp_cnt) begin n_fail++; $display("FAIL cont_cnt3: got %0d expected %0d", frame_cnt, exp_cnt); end
    tick();
    n_checks++; if ({frame_valid, busy, sel} !== 4'b0000) begin n_fail++; $display("FAIL cont_after_stop: got %b expected 0000", {frame_valid, busy, sel}); end
  endtask

  task automatic test_abort;
    in_vec = 4'b1001;
    cont = 1'b1;
    pulse_start();
    repeat (16) tick();
    exp_cnt = exp_cnt + 8'd1;
    n_checks++; if ({frame_valid, sample_o} !== 5'b11001) begin n_fail++; $display("FAIL abort_frame1: got %b expected 11001", {frame_valid, sample_o}); end
    in_vec = 4'b0110;
    repeat (9) tick();
    n_checks++; if (sel !== 2'd2) begin n_fail++; $display("FAIL abort_pre_sel: got %0d expected 2", sel); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_checks++; if ({busy, sel, frame_valid} !== 4'b0000) begin n_fail++; $display("FAIL abort_idle: got %b expected 0000", {busy, sel, frame_valid}); end
    n_checks++; if (sample_o !== 4'b1001) begin n_fail++; $display("FAIL abort_sample_kept: got %b expected 1001", sample_o); end
    n_checks++; if (frame_cnt !== exp_cnt) begin n_fail++; $display("FAIL abort_cnt_kept: got %0d expected %0d", frame_cnt, exp_cnt); end
    for (int n = 0; n < 20; n++) begin
      tick();
      n_checks++; if ({busy, frame_valid} !== 2'b00) begin n_fail++; $display("FAIL abort_quiet n=%0d: got %b expected 00", n, {busy, frame_valid}); end
    end
    cont = 1'b0;
    in_vec = 4'b0100;
    pulse_start();
    repeat (16) tick();
    exp_cnt = exp_cnt + 8'd1;
    n_checks++; if ({frame_valid, busy, sample_o} !== 6'b100100) begin n_fail++; $display("FAIL abort_restart: got %b expected 100100", {frame_valid, busy, sample_o}); end
    n_checks++; if (frame_cnt !== exp_cnt) begin n_fail++; $display("FAIL abort_restart_cnt: got %0d expected %0d", frame_cnt, exp_cnt); end
  endtask

  task automatic test_conflicts;
    logic [1:0] es;
    in_vec = 4'b0101;
    cont = 1'b0;
    pulse_start();
    for (int n = 0; n < 16; n++) begin
      start = (n == 2 || n == 7 || n == 13);
      es = 2'(n / 4);
      n_checks++; if (sel !== es) begin n_fail++; $display("FAIL busy_start_sel n=%0d: got %0d expected %0d", n, sel, es); end
      tick();
    end
    start = 1'b0;
    exp_cnt = exp_cnt + 8'd1;
    n_checks++; if ({frame_valid, busy, sample_o} !== 6'b100101) begin n_fail++; $display("FAIL busy_start_frame: got %b expected 100101", {frame_valid, busy, sample_o}); end
    tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL start_not_queued: got %b expected 0", busy); end
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    n_checks++; if ({busy, sel} !== 3'b000) begin n_fail++; $display("FAIL start_abort_idle: got %b expected 000", {busy, sel}); end
    tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL start_abort_idle2: got %b expected 0", busy); end
  endtask

  task automatic test_dwell1;
    logic [1:0] es;
    logic       efv;
    in1_vec = 4'b1010;
    cont1 = 1'b1;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int n = 0; n < 9; n++) begin
      es = 2'(n % 4);
      efv = (n == 4 || n == 8);
      n_checks++; if (sel1 !== es) begin n_fail++; $display("FAIL dwell1_sel n=%0d: got %0d expected %0d", n, sel1, es); end
      n_checks++; if (frame_valid1 !== efv) begin n_fail++; $display("FAIL dwell1_fv n=%0d: got %b expected %b", n, frame_valid1, efv); end
      if (efv) begin
        n_checks++; if (sample1_o !== 4'b1010) begin n_fail++; $display("FAIL dwell1_sample n=%0d: got %b expected 1010", n, sample1_o); end
      end
      tick();
    end
    cont1 = 1'b0;
    repeat (4) tick();
    n_checks++; if ({busy1, frame_cnt1} !== 9'd3) begin n_fail++; $display("FAIL dwell1_stop: got %h expected 003", {busy1, frame_cnt1}); end
  endtask

  task automatic test_wrap;
    int   w;
    logic seen_wrap;
    seen_wrap = 1'b0;
    in_vec = 4'b1100;
    cont = 1'b1;
    pulse_start();
    for (int f = 0; f < 256; f++) begin
      w = 0;
      while (frame_valid !== 1'b1 && w < 20) begin
        tick();
        w++;
      end
      n_checks++; if (frame_valid !== 1'b1) begin n_fail++; $display("FAIL wrap_timeout f=%0d: got %b expected 1", f, frame_valid); end
      exp_cnt = exp_cnt + 8'd1;
      n_checks++; if (frame_cnt !== exp_cnt) begin n_fail++; $display("FAIL wrap_cnt f=%0d: got %0d expected %0d", f, frame_cnt, exp_cnt); end
      if (frame_cnt === 8'd0 && exp_cnt === 8'd0) seen_wrap = 1'b1;
      tick();
    end
    n_checks++; if (seen_wrap !== 1'b1) begin n_fail++; $display("FAIL wrap_seen: got %b expected 1", seen_wrap); end
    cont = 1'b0;
    w = 0;
    while (busy !== 1'b0 && w < 20) begin
      tick();
      w++;
    end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wrap_stop: got %b expected 0", busy); end
  endtask

  initial begin
    start = 1'b0; abort = 1'b0; cont = 1'b0; in_vec = 4'b0000;
    start1 = 1'b0; abort1 = 1'b0; cont1 = 1'b0; in1_vec = 4'b0000;
    rst_n = 1'b0;
    exp_cnt = 8'd0;
    test_reset();
    test_single();
    test_async_reset();
    test_continuous();
    test_abort();
    test_conflicts();
    test_dwell1();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
